// File: rtl/l15_data_refill_arb_if.sv
// Bundle of the refill, read and data-RAM signals around the L1.5
// instruction-cache data RAM front-end.
//   slave  : the arbiter's view (refill/read requests and RAM read data in;
//            handshakes, read data and RAM command out)
//   master : the surrounding logic's view (refill path, lookup stage and the
//            RAM model drive what the arbiter consumes)
interface l15_data_refill_arb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int LINE_WORDS = 4,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    localparam int OFS    = $clog2(LINE_WORDS);
    localparam int LINE_W = ADDR_WIDTH - OFS;

    // refill path
    logic                  refill_start_i;
    logic [LINE_W-1:0]     refill_line_i;
    logic                  refill_busy_o;
    logic                  refill_valid_i;
    logic [DATA_WIDTH-1:0] refill_data_i;
    logic                  refill_ready_o;
    logic                  refill_done_o;
    // lookup-stage reads
    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  rd_gnt_o;
    logic                  rd_rvalid_o;
    logic [DATA_WIDTH-1:0] rd_rdata_o;
    // single-port data RAM
    logic                  mem_req_o;
    logic                  mem_write_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  refill_start_i, refill_line_i, refill_valid_i, refill_data_i,
        input  rd_req_i, rd_addr_i, mem_rdata_i,
        output refill_busy_o, refill_ready_o, refill_done_o,
        output rd_gnt_o, rd_rvalid_o, rd_rdata_o,
        output mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output refill_start_i, refill_line_i, refill_valid_i, refill_data_i,
        output rd_req_i, rd_addr_i, mem_rdata_i,
        input  refill_busy_o, refill_ready_o, refill_done_o,
        input  rd_gnt_o, rd_rvalid_o, rd_rdata_o,
        input  mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/l15_data_refill_arb.sv
// Front-end of the L1.5 instruction-cache data RAM.
// Sequences line-refill beats into consecutive RAM words, arbitrates them
// against lookup reads (refill writes win) and blocks reads to the line that
// is currently being refilled.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : slave view of l15_data_refill_arb_if (refill handshake, read
//           request/grant/response, single-port RAM command and read data)
module l15_data_refill_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int LINE_WORDS = 4,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l15_data_refill_arb_if.slave  bus
);
    localparam int OFS    = $clog2(LINE_WORDS);
    localparam int LINE_W = ADDR_WIDTH - OFS;
    localparam logic [OFS-1:0] LAST_WORD = OFS'(LINE_WORDS - 1);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t            state_reg;
    logic [LINE_W-1:0] line_reg;
    logic [OFS-1:0]    cnt_reg;
    logic              done_reg;
    logic              rvalid_reg;

    logic              in_fill;
    logic              beat;
    logic              same_line;
    logic              rd_gnt;
    logic [BE_WIDTH-1:0] be_all;

    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_be_all
            assign be_all[gi] = 1'b1;
        end
    endgenerate

    // Combinational outputs are qualified with rst_n so nothing reaches the
    // RAM or the requesters while reset is held.
    assign in_fill   = rst_n & (state_reg == FILL);
    assign beat      = in_fill & bus.refill_valid_i;
    assign same_line = (bus.rd_addr_i[ADDR_WIDTH-1:OFS] == line_reg);
    // Writes take the RAM first; reads into the half-written line must wait
    // until the refill has finished.
    assign rd_gnt    = rst_n & bus.rd_req_i & ~beat & ~(in_fill & same_line);

    assign bus.refill_busy_o  = in_fill;
    assign bus.refill_ready_o = in_fill;
    assign bus.refill_done_o  = done_reg;
    assign bus.rd_gnt_o       = rd_gnt;
    assign bus.rd_rvalid_o    = rvalid_reg;
    assign bus.rd_rdata_o     = bus.mem_rdata_i;

    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_be_o    = '0;
        if (beat) begin
            bus.mem_req_o   = 1'b1;
            bus.mem_write_o = 1'b1;
            bus.mem_addr_o  = {line_reg, cnt_reg};
            bus.mem_wdata_o = bus.refill_data_i;
            bus.mem_be_o    = be_all;
        end else if (rd_gnt) begin
            bus.mem_req_o   = 1'b1;
            bus.mem_addr_o  = bus.rd_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            line_reg   <= '0;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            rvalid_reg <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            rvalid_reg <= rd_gnt;
            case (state_reg)
                IDLE: begin
                    if (bus.refill_start_i) begin
                        line_reg  <= bus.refill_line_i;
                        cnt_reg   <= '0;
                        state_reg <= FILL;
                    end
                end
                FILL: begin
                    // No beat simply holds the counter; the refill has no timeout.
                    if (bus.refill_valid_i) begin
                        cnt_reg <= cnt_reg + OFS'(1);
                        if (cnt_reg == LAST_WORD) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l15_data_refill_arb.sv
module tb_l15_data_refill_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    l15_data_refill_arb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(7), .LINE_WORDS(4)) bus ();

    l15_data_refill_arb #(.DATA_WIDTH(64), .ADDR_WIDTH(7), .LINE_WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural single-port RAM, 1-cycle read latency; filled with an
    // address pattern on the first clock so unwritten words are recognisable.
    logic [63:0] ram [128];
    bit          ram_ready;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 128; i++) ram[i] <= {32'hC0DE_0000, 32'(i)};
            ram_ready <= 1'b1;
        end else if (bus.mem_req_o) begin
            if (bus.mem_write_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
            else                 bus.mem_rdata_i     <= ram[bus.mem_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input int addr, input logic [63:0] data);
        chk({tag, "_req"},   64'(bus.mem_req_o),   64'd1);
        chk({tag, "_write"}, 64'(bus.mem_write_o), 64'd1);
        chk({tag, "_addr"},  64'(bus.mem_addr_o),  64'(addr));
        chk({tag, "_wdata"}, bus.mem_wdata_o,      data);
        chk({tag, "_be"},    64'(bus.mem_be_o),    64'hFF);
    endtask

    task automatic chk_read(input string tag, input int addr);
        chk({tag, "_gnt"},   64'(bus.rd_gnt_o),    64'd1);
        chk({tag, "_req"},   64'(bus.mem_req_o),   64'd1);
        chk({tag, "_write"}, 64'(bus.mem_write_o), 64'd0);
        chk({tag, "_addr"},  64'(bus.mem_addr_o),  64'(addr));
        chk({tag, "_be"},    64'(bus.mem_be_o),    64'd0);
        chk({tag, "_wdata"}, bus.mem_wdata_o,      64'd0);
    endtask

    initial begin
        // Reset with every request active: nothing may leak out.
        rst_n = 1'b0;
        bus.refill_start_i = 1'b1;
        bus.refill_line_i  = 5'd9;
        bus.refill_valid_i = 1'b1;
        bus.refill_data_i  = 64'hFFFF;
        bus.rd_req_i       = 1'b1;
        bus.rd_addr_i      = 7'd40;
        tick();
        chk("rst_gnt",   64'(bus.rd_gnt_o),       64'd0);
        chk("rst_req",   64'(bus.mem_req_o),      64'd0);
        chk("rst_ready", 64'(bus.refill_ready_o), 64'd0);
        chk("rst_busy",  64'(bus.refill_busy_o),  64'd0);
        tick();
        chk("rst_rvalid", 64'(bus.rd_rvalid_o),   64'd0);
        chk("rst_done",   64'(bus.refill_done_o), 64'd0);
        rst_n = 1'b1;
        bus.refill_start_i = 1'b0;
        bus.refill_valid_i = 1'b0;
        bus.rd_req_i       = 1'b0;
        #1;
        chk("post_rst_busy",   64'(bus.refill_busy_o), 64'd0);
        chk("post_rst_done",   64'(bus.refill_done_o), 64'd0);
        chk("post_rst_rvalid", 64'(bus.rd_rvalid_o),   64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_req",  64'(bus.mem_req_o),     64'd0);
            chk("idle_busy", 64'(bus.refill_busy_o), 64'd0);
        end

        // Back-to-back refill of line 5 -> addr 20..23.
        tick();
        bus.refill_start_i = 1'b1;
        bus.refill_line_i  = 5'd5;
        #1;
        chk("b2b_start_req", 64'(bus.mem_req_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.refill_start_i = 1'b0;
            bus.refill_valid_i = 1'b1;
            bus.refill_data_i  = 64'hA0 + 64'(i);
            #1;
            chk("b2b_busy",  64'(bus.refill_busy_o),  64'd1);
            chk("b2b_ready", 64'(bus.refill_ready_o), 64'd1);
            chk("b2b_done",  64'(bus.refill_done_o),  64'd0);
            chk_write("b2b", 20 + i, 64'hA0 + 64'(i));
        end
        tick();
        bus.refill_valid_i = 1'b0;
        #1;
        chk("b2b_done_pulse", 64'(bus.refill_done_o), 64'd1);
        chk("b2b_busy_low",   64'(bus.refill_busy_o), 64'd0);
        chk("b2b_req_low",    64'(bus.mem_req_o),     64'd0);
        tick();
        chk("b2b_done_end",   64'(bus.refill_done_o), 64'd0);

        // Stalled refill of line 2 with a read to another line in the gap.
        tick();
        bus.refill_start_i = 1'b1;
        bus.refill_line_i  = 5'd2;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.refill_start_i = 1'b0;
            bus.refill_valid_i = 1'b1;
            bus.refill_data_i  = 64'hB0 + 64'(i);
            #1;
            chk_write("stall_beat", 8 + i, 64'hB0 + 64'(i));
        end
        tick();
        bus.refill_valid_i = 1'b0;
        bus.rd_req_i       = 1'b1;
        bus.rd_addr_i      = 7'd40;
        #1;
        chk_read("stall_gap_rd", 40);
        chk("stall_gap_busy", 64'(bus.refill_busy_o), 64'd1);
        tick();
        bus.rd_req_i       = 1'b0;
        bus.refill_valid_i = 1'b1;
        bus.refill_data_i  = 64'hB2;
        #1;
        chk("stall_rvalid", 64'(bus.rd_rvalid_o), 64'd1);
        chk("stall_rdata",  bus.rd_rdata_o,       64'hC0DE_0000_0000_0028);
        chk_write("stall_resume", 10, 64'hB2);
        tick();
        bus.refill_data_i = 64'hB3;
        #1;
        chk("stall_rvalid_end", 64'(bus.rd_rvalid_o), 64'd0);
        chk_write("stall_last", 11, 64'hB3);
        tick();
        bus.refill_valid_i = 1'b0;
        #1;
        chk("stall_done", 64'(bus.refill_done_o), 64'd1);

        // Refill of line 3: read in the start cycle, then same-line hazard.
        tick();
        bus.refill_start_i = 1'b1;
        bus.refill_line_i  = 5'd3;
        bus.rd_req_i       = 1'b1;
        bus.rd_addr_i      = 7'd12;
        #1;
        chk_read("haz_start_rd", 12);
        tick();
        bus.refill_start_i = 1'b0;
        #1;
        chk("haz_rvalid0", 64'(bus.rd_rvalid_o), 64'd1);
        chk("haz_rdata0",  bus.rd_rdata_o,       64'hC0DE_0000_0000_000C);
        chk("haz_blk_gnt", 64'(bus.rd_gnt_o),    64'd0);
        chk("haz_blk_req", 64'(bus.mem_req_o),   64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.refill_valid_i = 1'b1;
            bus.refill_data_i  = 64'hC0 + 64'(i);
            #1;
            chk("haz_beat_gnt", 64'(bus.rd_gnt_o), 64'd0);
            chk_write("haz_beat", 12 + i, 64'hC0 + 64'(i));
        end
        tick();
        bus.refill_valid_i = 1'b0;
        #1;
        chk("haz_done",   64'(bus.refill_done_o), 64'd1);
        chk("haz_rvalid", 64'(bus.rd_rvalid_o),   64'd0);
        chk_read("haz_after_done", 12);
        tick();
        bus.rd_req_i = 1'b0;
        #1;
        chk("haz_rb_rvalid", 64'(bus.rd_rvalid_o), 64'd1);
        chk("haz_rb_rdata",  bus.rd_rdata_o,       64'hC0);

        // Refill line 3 again: other-line read loses to a beat, wins the gap.
        tick();
        bus.refill_start_i = 1'b1;
        bus.refill_line_i  = 5'd3;
        #1;
        tick();
        bus.refill_start_i = 1'b0;
        bus.refill_valid_i = 1'b1;
        bus.refill_data_i  = 64'hD0;
        bus.rd_req_i       = 1'b1;
        bus.rd_addr_i      = 7'd0;
        #1;
        chk("prio_gnt", 64'(bus.rd_gnt_o), 64'd0);
        chk_write("prio_beat", 12, 64'hD0);
        tick();
        bus.refill_valid_i = 1'b0;
        #1;
        chk_read("prio_gap_rd", 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            bus.rd_req_i       = 1'b0;
            bus.refill_valid_i = 1'b1;
            bus.refill_data_i  = 64'hD0 + 64'(i);
            #1;
            if (i == 1) begin
                chk("prio_rvalid", 64'(bus.rd_rvalid_o), 64'd1);
                chk("prio_rdata",  bus.rd_rdata_o,       64'hC0DE_0000_0000_0000);
            end
            chk_write("prio_beat", 12 + i, 64'hD0 + 64'(i));
        end
        tick();
        bus.refill_valid_i = 1'b0;
        #1;
        chk("prio_done", 64'(bus.refill_done_o), 64'd1);

        // Reset in the middle of a refill of line 6.
        tick();
        bus.refill_start_i = 1'b1;
        bus.refill_line_i  = 5'd6;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.refill_start_i = 1'b0;
            bus.refill_valid_i = 1'b1;
            bus.refill_data_i  = 64'hE0 + 64'(i);
            #1;
            chk_write("mid_beat", 24 + i, 64'hE0 + 64'(i));
        end
        tick();
        bus.refill_valid_i = 1'b0;
        bus.rd_req_i       = 1'b1;
        bus.rd_addr_i      = 7'd40;
        #1;
        chk_read("mid_rd", 40);
        tick();
        rst_n = 1'b0;
        bus.refill_valid_i = 1'b1;
        #1;
        chk("mid_rst_gnt",   64'(bus.rd_gnt_o),       64'd0);
        chk("mid_rst_req",   64'(bus.mem_req_o),      64'd0);
        chk("mid_rst_ready", 64'(bus.refill_ready_o), 64'd0);
        chk("mid_rst_busy",  64'(bus.refill_busy_o),  64'd0);
        tick();
        rst_n = 1'b1;
        bus.refill_valid_i = 1'b0;
        bus.rd_req_i       = 1'b0;
        #1;
        chk("mid_post_busy",   64'(bus.refill_busy_o), 64'd0);
        chk("mid_post_done",   64'(bus.refill_done_o), 64'd0);
        chk("mid_post_rvalid", 64'(bus.rd_rvalid_o),   64'd0);
        tick();
        chk("mid_no_done", 64'(bus.refill_done_o), 64'd0);
        chk("mid_no_req",  64'(bus.mem_req_o),     64'd0);

        // Fresh refill of line 1 starts again at word 0.
        bus.refill_start_i = 1'b1;
        bus.refill_line_i  = 5'd1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.refill_start_i = 1'b0;
            bus.refill_valid_i = 1'b1;
            bus.refill_data_i  = 64'hF0 + 64'(i);
            #1;
            chk_write("l1_beat", 4 + i, 64'hF0 + 64'(i));
        end
        // Next refill (line 0) is started in the cycle the done pulse is high.
        tick();
        bus.refill_valid_i = 1'b0;
        bus.refill_start_i = 1'b1;
        bus.refill_line_i  = 5'd0;
        #1;
        chk("l1_done", 64'(bus.refill_done_o), 64'd1);
        chk("l1_busy", 64'(bus.refill_busy_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.refill_start_i = 1'b0;
            bus.refill_valid_i = 1'b1;
            bus.refill_data_i  = 64'h11 * 64'(i + 1);
            #1;
            chk("l0_busy", 64'(bus.refill_busy_o), 64'd1);
            chk_write("l0_beat", i, 64'h11 * 64'(i + 1));
        end

        // Read line 0 back at full throughput.
        tick();
        bus.refill_valid_i = 1'b0;
        bus.rd_req_i       = 1'b1;
        bus.rd_addr_i      = 7'd0;
        #1;
        chk("l0_done", 64'(bus.refill_done_o), 64'd1);
        chk_read("rb_rd", 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            bus.rd_addr_i = 7'(i);
            #1;
            chk_read("rb_rd", i);
            chk("rb_rvalid", 64'(bus.rd_rvalid_o), 64'd1);
            chk("rb_rdata",  bus.rd_rdata_o,       64'h11 * 64'(i));
        end
        tick();
        bus.rd_req_i = 1'b0;
        #1;
        chk("rb_rvalid_last", 64'(bus.rd_rvalid_o), 64'd1);
        chk("rb_rdata_last",  bus.rd_rdata_o,       64'h44);
        tick();
        chk("rb_rvalid_end", 64'(bus.rd_rvalid_o), 64'd0);
        chk("rb_req_end",    64'(bus.mem_req_o),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
